// File: rtl/hello_out_monitor_pkg.sv
// ============================================================================
// hello_mon_pkg : shared types and constants for the HelloWorld output monitor
// Revision 1.0
// ============================================================================
`default_nettype none

package hello_mon_pkg;

  localparam int HM_Z_W  = 6;
  localparam int HM_TS_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRIME   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  typedef struct packed {
    logic               init;
    logic [HM_TS_W-1:0] ts;
    logic [HM_Z_W-1:0]  z;
  } ev_t;

  // x^16 + x^12 + x^3 + x + 1
  localparam logic [15:0] c_MISR_POLY = 16'h100B;
  localparam logic [15:0] c_MISR_SEED = 16'hFFFF;

  function automatic logic [15:0] misr_step(input logic [15:0] cur, input logic [15:0] din);
    misr_step = {cur[14:0], 1'b0} ^ (cur[15] ? c_MISR_POLY : 16'h0000) ^ din;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hello_out_monitor_if.sv
// ============================================================================
// hello_out_monitor_if : valid/ready event port of the output monitor
// Revision 1.0
// ============================================================================
`default_nettype none

interface hello_out_monitor_if
  import hello_mon_pkg::*;
#(
  parameter int Z_W  = HM_Z_W,
  parameter int TS_W = HM_TS_W
);
  logic            ev_valid;
  logic            ev_ready;
  logic [Z_W-1:0]  ev_z;
  logic [TS_W-1:0] ev_ts;
  logic            ev_init;

  modport master (output ev_valid, ev_z, ev_ts, ev_init, input ev_ready);
  modport slave  (input ev_valid, ev_z, ev_ts, ev_init, output ev_ready);
endinterface

`default_nettype wire

// File: rtl/hello_out_monitor_fifo.sv
// ============================================================================
// hello_mon_fifo : synchronous show-ahead FIFO; pop on empty is ignored and a
// push on full succeeds only when a pop frees a slot in the same cycle.
// Revision 1.0
// ============================================================================
`default_nettype none

module hello_mon_fifo #(
  parameter int WIDTH = 23,
  parameter int DEPTH = 8
) (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  input  wire logic                     push_i,
  input  wire logic                     pop_i,
  input  wire logic [WIDTH-1:0]         wdata_i,
  output logic      [WIDTH-1:0]         rdata_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic      [$clog2(DEPTH):0]   level_o
);
  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty_o   = (level_q == '0);
  assign full_o    = (level_q == LVL_W'(DEPTH));
  assign level_o   = level_q;
  assign w_do_pop  = pop_i && !empty_o;
  assign w_do_push = push_i && (!full_o || w_do_pop);
  // Masked so the head reads as zero whenever nothing is queued.
  assign rdata_o   = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (w_do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (w_do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/hello_out_monitor.sv
// ============================================================================
// hello_out_monitor : timestamps every change of the z vector into an event
// FIFO. Optional signature register enabled by HELLO_OUT_MONITOR_MISR_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module hello_out_monitor
  import hello_mon_pkg::*;
#(
  parameter int Z_W   = HM_Z_W,
  parameter int TS_W  = HM_TS_W,
  parameter int DEPTH = 8
) (
  input  wire logic                     bertaClock,
  input  wire logic                     global_reset,
  input  wire logic                     arm,
  input  wire logic [Z_W-1:0]           z,
  hello_out_monitor_if.master           ev,
  output logic      [$clog2(DEPTH):0]   level,
  output logic                          overflow,
`ifdef HELLO_OUT_MONITOR_MISR_EN
  output logic      [15:0]              misr,
`endif
  output logic      [7:0]               drops
);
  localparam int EV_W = 1 + TS_W + Z_W;

  state_t          state_q;
  logic [Z_W-1:0]  zs1_q;
  logic [Z_W-1:0]  zs2_q;
  logic [Z_W-1:0]  z_prev_q;
  logic [TS_W-1:0] ts_q;
  logic            overflow_q;
  logic [7:0]      drops_q;

  logic            w_push_prime;
  logic            w_push_chg;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic [EV_W-1:0] w_wdata;
  logic [EV_W-1:0] w_rdata;

  // ts is still 0 during PRIME, so one packing serves both event kinds.
  assign w_push_prime = (state_q == PRIME);
  assign w_push_chg   = (state_q == CAPTURE) && arm && (zs2_q != z_prev_q);
  assign w_push       = w_push_prime || w_push_chg;
  assign w_wdata      = {w_push_prime, ts_q, zs2_q};
  assign w_pop        = ev.ev_valid && ev.ev_ready;

  always_ff @(posedge bertaClock or negedge global_reset) begin
    if (!global_reset) begin
      zs1_q <= '0;
      zs2_q <= '0;
    end else begin
      zs1_q <= z;
      zs2_q <= zs1_q;
    end
  end

  always_ff @(posedge bertaClock or negedge global_reset) begin
    if (!global_reset) begin
      state_q  <= IDLE;
      z_prev_q <= '0;
      ts_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ts_q <= '0;
          if (arm) state_q <= PRIME;
        end
        PRIME: begin
          z_prev_q <= zs2_q;
          ts_q     <= TS_W'(1);
          state_q  <= CAPTURE;
        end
        CAPTURE: begin
          if (!arm) begin
            ts_q    <= '0;
            state_q <= IDLE;
          end else begin
            if (ts_q != '1) ts_q <= ts_q + TS_W'(1);
            // z_prev follows even when the event is dropped.
            if (w_push_chg) z_prev_q <= zs2_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge bertaClock or negedge global_reset) begin
    if (!global_reset) begin
      overflow_q <= 1'b0;
      drops_q    <= '0;
    end else if (w_push && w_full && !w_pop) begin
      overflow_q <= 1'b1;
      if (drops_q != 8'hFF) drops_q <= drops_q + 8'd1;
    end
  end

  hello_mon_fifo #(
    .WIDTH (EV_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (bertaClock),
    .rst_n   (global_reset),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .wdata_i (w_wdata),
    .rdata_o (w_rdata),
    .full_o  (w_full),
    .empty_o (w_empty),
    .level_o (level)
  );

  assign ev.ev_valid = !w_empty;
  assign {ev.ev_init, ev.ev_ts, ev.ev_z} = w_rdata;
  assign overflow = overflow_q;
  assign drops    = drops_q;

`ifdef HELLO_OUT_MONITOR_MISR_EN
  logic [15:0] misr_q;

  always_ff @(posedge bertaClock or negedge global_reset) begin
    if (!global_reset) begin
      misr_q <= '0;
    end else if (state_q == PRIME) begin
      misr_q <= c_MISR_SEED;
    end else if (state_q == CAPTURE) begin
      misr_q <= misr_step(misr_q, 16'(zs2_q));
    end
  end

  assign misr = misr_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hello_out_monitor.sv
// ============================================================================
// tb_hello_out_monitor : directed self-checking bench for hello_out_monitor
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_hello_out_monitor;
  import hello_mon_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       arm;
  logic [5:0] z;
  logic [3:0] level;
  logic       overflow;
  logic [7:0] drops;
`ifdef HELLO_OUT_MONITOR_MISR_EN
  logic [15:0] misr;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hello_out_monitor_if #(.Z_W(6), .TS_W(16)) ev_if ();

  hello_out_monitor #(.Z_W(6), .TS_W(16), .DEPTH(8)) dut (
    .bertaClock   (clk),
    .global_reset (rst_n),
    .arm          (arm),
    .z            (z),
    .ev           (ev_if),
    .level        (level),
    .overflow     (overflow),
`ifdef HELLO_OUT_MONITOR_MISR_EN
    .misr         (misr),
`endif
    .drops        (drops)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic ev_t mk_ev(input logic [5:0] ez, input logic [15:0] ets, input logic einit);
    ev_t e;
    e.z    = ez;
    e.ts   = ets;
    e.init = einit;
    return e;
  endfunction

  task automatic check_head(input string tag, input ev_t e);
    check({tag, ".valid"}, 32'(ev_if.ev_valid), 32'd1);
    check({tag, ".z"},     32'(ev_if.ev_z),     32'(e.z));
    check({tag, ".ts"},    32'(ev_if.ev_ts),    32'(e.ts));
    check({tag, ".init"},  32'(ev_if.ev_init),  32'(e.init));
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  ev_t exp_q[$];

  initial begin
    rst_n          = 1'b0;
    arm            = 1'b0;
    z              = 6'h00;
    ev_if.ev_ready = 1'b0;
    tick(2);
    check("rst.valid",    32'(ev_if.ev_valid), 32'd0);
    check("rst.z",        32'(ev_if.ev_z),     32'd0);
    check("rst.ts",       32'(ev_if.ev_ts),    32'd0);
    check("rst.init",     32'(ev_if.ev_init),  32'd0);
    check("rst.level",    32'(level),          32'd0);
    check("rst.overflow", 32'(overflow),       32'd0);
    check("rst.drops",    32'(drops),          32'd0);
    rst_n = 1'b1;
    tick(1);

    // Arm with z held at 0: one init event, nothing else.
    arm = 1'b1;
    tick(4);
    check("arm.level", 32'(level), 32'd1);
    check_head("arm.head", mk_ev(6'h00, 16'd0, 1'b1));
    tick(3);
    check("arm.level_hold", 32'(level), 32'd1);

    // Edge 8 pops the init event; z set after edge 9 is compared while ts=10.
    ev_if.ev_ready = 1'b1;
    tick(1);
    check("pop.level", 32'(level), 32'd0);
    tick(1);
    z = 6'h2A;
    tick(1);
    check("chg.valid_e1", 32'(ev_if.ev_valid), 32'd0);
    tick(1);
    check("chg.valid_e2", 32'(ev_if.ev_valid), 32'd0);
    tick(1);
    check_head("chg.head", mk_ev(6'h2A, 16'd10, 1'b0));
    tick(1);
    check("chg.drained", 32'(level), 32'd0);

    // Re-arm, then ten changes with the consumer stalled.
    ev_if.ev_ready = 1'b0;
    arm = 1'b0;
    tick(1);
    arm = 1'b1;
    tick(2);
    check("rearm.level", 32'(level), 32'd1);
    for (int k = 1; k <= 10; k++) begin
      z = 6'(k);
      tick(1);
    end
    tick(2);
    check("ovf.level",    32'(level),    32'd8);
    check("ovf.overflow", 32'(overflow), 32'd1);
    check("ovf.drops",    32'(drops),    32'd3);
    check_head("ovf.head", mk_ev(6'h2A, 16'd0, 1'b1));

    // Push and pop together on a full FIFO.
    z = 6'h15;
    tick(2);
    ev_if.ev_ready = 1'b1;
    tick(1);
    ev_if.ev_ready = 1'b0;
    check("pp.level", 32'(level), 32'd8);
    check("pp.drops", 32'(drops), 32'd3);
    for (int i = 0; i < 7; i++) exp_q.push_back(mk_ev(6'(i + 1), 16'(i + 3), 1'b0));
    exp_q.push_back(mk_ev(6'h15, 16'd15, 1'b0));
    for (int i = 0; i < 8; i++) begin
      check_head($sformatf("drain%0d", i), exp_q.pop_front());
      ev_if.ev_ready = 1'b1;
      tick(1);
    end
    check("drain.level", 32'(level),          32'd0);
    check("drain.valid", 32'(ev_if.ev_valid), 32'd0);
    tick(2);
    check("empty.level", 32'(level), 32'd0);

    // A queued change event, then re-arm behind it.
    ev_if.ev_ready = 1'b0;
    z = 6'h33;
    tick(3);
    check("q.level", 32'(level), 32'd1);
    arm = 1'b0;
    tick(1);
    arm = 1'b1;
    tick(2);
    check("re.level",    32'(level),    32'd2);
    check("re.overflow", 32'(overflow), 32'd1);
    check("re.drops",    32'(drops),    32'd3);
    check_head("re.first", mk_ev(6'h33, 16'd28, 1'b0));
    ev_if.ev_ready = 1'b1;
    tick(1);
    ev_if.ev_ready = 1'b0;
    check_head("re.second", mk_ev(6'h33, 16'd0, 1'b1));

    // Asynchronous reset between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.valid",    32'(ev_if.ev_valid), 32'd0);
    check("arst.level",    32'(level),          32'd0);
    check("arst.overflow", 32'(overflow),       32'd0);
    check("arst.drops",    32'(drops),          32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
